// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command receiver.
//   parity_e   : parity mode encoding used by the PARITY parameter
//   rx_state_e : receive FSM state encoding
//   calc_div   : clocks per oversample tick, rounded to nearest, minimum 1
//   maj3       : 2-of-3 majority vote used by the bit sampler
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    if (d < 1) d = 1;
    return d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push_i     : write wdata_i; refused when full unless a pop happens too
//   wdata_i    : write data
//   pop_i      : remove the head; ignored while empty
//   rdata_o    : head entry, forced to 0 while empty
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   level_o    : entries held, 0..DEPTH
//   ovf_o      : push refused this cycle (full, no pop)
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (lvl_q == '0);
    full_o  = (lvl_q == (AW+1)'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    ovf_o   = push_i & full_o & ~do_pop;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q;
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + (AW+1)'(1);
      2'b01:   lvl_d = lvl_q - (AW+1)'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Oversampling UART receiver with tag check and command-code FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx           : serial line (asynchronous, idles high)
//   m_data       : FIFO head code, valid while m_valid
//   m_valid      : FIFO not empty
//   m_ready      : consumer takes the head this cycle
//   fifo_level   : entries held, 0..DEPTH
//   busy         : receive FSM not idle
//   err_frame    : pulse, stop bit sampled low
//   err_parity   : pulse, parity mismatch
//   err_tag      : pulse, tag field mismatch
//   err_overflow : pulse, good code dropped on a full FIFO
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int               CLK_FREQ  = 50_000_000,
  parameter int               BAUD      = 9600,
  parameter int               OVS       = 16,
  parameter int               DATA_BITS = 8,
  parameter int               PARITY    = 0,
  parameter int               TAG_W     = 2,
  parameter logic [TAG_W-1:0] TAG       = 2'b01,
  parameter int               CODE_W    = 2,
  parameter int               DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [CODE_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      busy,
  output logic                      err_frame,
  output logic                      err_parity,
  output logic                      err_tag,
  output logic                      err_overflow
);

  localparam int  DIV     = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int  DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int  PH_W    = $clog2(OVS);
  localparam int  BC_W    = $clog2(DATA_BITS);
  localparam bit  HAS_PAR = (PARITY != int'(PAR_NONE));
  localparam bit  ODD_PAR = (PARITY == int'(PAR_ODD));

  if (OVS < 8 || (OVS % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      TAG_W + CODE_W > DATA_BITS || PARITY < 0 || PARITY > 2) begin : g_param_err
    $error("uart_cmd_rx: illegal parameter set");
  end

  rx_state_e           state_q, state_d;
  logic                rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [1:0]          smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                par_err_q, par_err_d;
  logic                push_q, push_d;
  logic                err_frame_q, err_frame_d;
  logic                err_parity_q, err_parity_d;
  logic                err_tag_q, err_tag_d;

  logic tick, dec, eob, sample, start_edge, last_data, tag_bad;
  logic restart, shift_en, par_en, frame_good, frame_bad;
  logic fifo_empty, fifo_full;

  // Synchroniser and edge detect. The flops clear to 0 so that the line must
  // be observed high after reset before any falling edge can count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s_q;
  assign tick       = (div_q == DIV_W'(DIV - 1));
  assign dec        = tick & (ph_q == PH_W'(OVS / 2 + 1));
  assign eob        = tick & (ph_q == PH_W'(OVS - 1));
  // The third vote is the live line at the decision tick.
  assign sample     = maj3(smp_q[0], smp_q[1], rx_s_q);
  assign last_data  = (bcnt_q == BC_W'(DATA_BITS - 1));
  assign tag_bad    = (shreg_q[TAG_W-1:0] != TAG);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_edge) state_d = ST_START;
      ST_START: begin
        if (dec && sample) state_d = ST_IDLE;
        else if (eob)      state_d = ST_DATA;
      end
      ST_DATA:      if (eob && last_data) state_d = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (eob) state_d = ST_STOP;
      // Leave at the stop-bit midpoint to regain half a bit of margin.
      ST_STOP:      if (dec) state_d = sample ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s_q) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != ST_IDLE);
    restart    = (state_q == ST_IDLE) & start_edge;
    shift_en   = (state_q == ST_DATA) & dec;
    par_en     = (state_q == ST_PARITY) & dec;
    frame_good = (state_q == ST_STOP) & dec & sample;
    frame_bad  = (state_q == ST_STOP) & dec & ~sample;
  end

  // Sampler / datapath next state
  always_comb begin
    div_d = (restart || tick) ? '0 : div_q + DIV_W'(1);

    ph_d = ph_q;
    if (state_q == ST_IDLE) ph_d = '0;
    else if (tick)          ph_d = eob ? '0 : ph_q + PH_W'(1);

    smp_d = smp_q;
    if (tick && ph_q == PH_W'(OVS / 2 - 1)) smp_d[0] = rx_s_q;
    if (tick && ph_q == PH_W'(OVS / 2))     smp_d[1] = rx_s_q;

    bcnt_d = '0;
    if (state_q == ST_DATA) bcnt_d = eob ? bcnt_q + BC_W'(1) : bcnt_q;

    shreg_d = shift_en ? {sample, shreg_q[DATA_BITS-1:1]} : shreg_q;

    par_err_d = par_err_q;
    if (restart)     par_err_d = 1'b0;
    else if (par_en) par_err_d = sample ^ (^shreg_q) ^ ODD_PAR;

    // Priority: frame > parity > tag; exactly one outcome per character.
    err_frame_d  = frame_bad;
    err_parity_d = frame_good & par_err_q;
    err_tag_d    = frame_good & ~par_err_q & tag_bad;
    push_d       = frame_good & ~par_err_q & ~tag_bad;
    code_d       = frame_good ? shreg_q[TAG_W +: CODE_W] : code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      ph_q         <= '0;
      bcnt_q       <= '0;
      par_err_q    <= 1'b0;
      push_q       <= 1'b0;
      err_frame_q  <= 1'b0;
      err_parity_q <= 1'b0;
      err_tag_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      ph_q         <= ph_d;
      bcnt_q       <= bcnt_d;
      par_err_q    <= par_err_d;
      push_q       <= push_d;
      err_frame_q  <= err_frame_d;
      err_parity_q <= err_parity_d;
      err_tag_q    <= err_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    smp_q   <= smp_d;
    shreg_q <= shreg_d;
    code_q  <= code_d;
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (code_q),
    .pop_i   (m_valid & m_ready),
    .rdata_o (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .ovf_o   (err_overflow)
  );

  assign m_valid    = ~fifo_empty;
  assign err_frame  = err_frame_q;
  assign err_parity = err_parity_q;
  assign err_tag    = err_tag_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: 16 clocks per bit, TAG=01. A queue model predicts
// FIFO contents and error pulses from the character rules; a second
// instance built with even parity covers the parity path.
module tb_uart_cmd_rx;

  localparam int DEPTH   = 4;
  localparam int K_PUSH  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;
  localparam int K_TAG   = 3;
  // rx falls after edge k: synchroniser 2, start detect 1, stop-bit
  // decision at bit 9 tick 9, outcome registered one clock later.
  localparam int LAT     = 3 + 9 * 16 + 9 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       m_ready = 1'b1, m_ready_p = 1'b1;
  logic [1:0] m_data, m_data_p;
  logic [2:0] fifo_level, fifo_level_p;
  logic       m_valid, busy, err_frame, err_parity, err_tag, err_overflow;
  logic       m_valid_p, busy_p, err_frame_p, err_parity_p, err_tag_p, err_overflow_p;

  uart_cmd_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16), .DATA_BITS(8), .PARITY(0),
    .TAG_W(2), .TAG(2'b01), .CODE_W(2), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_level(fifo_level), .busy(busy),
    .err_frame(err_frame), .err_parity(err_parity), .err_tag(err_tag),
    .err_overflow(err_overflow)
  );

  uart_cmd_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16), .DATA_BITS(8), .PARITY(1),
    .TAG_W(2), .TAG(2'b01), .CODE_W(2), .DEPTH(DEPTH)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .m_data(m_data_p), .m_valid(m_valid_p),
    .m_ready(m_ready_p), .fifo_level(fifo_level_p), .busy(busy_p),
    .err_frame(err_frame_p), .err_parity(err_parity_p), .err_tag(err_tag_p),
    .err_overflow(err_overflow_p)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state for the main instance.
  typedef struct { int cyc; int kind; logic [1:0] code; } ev_t;
  ev_t        evq[$];
  logic [1:0] mq[$];
  int         ev_kind;
  logic [1:0] ev_code, exp_head;
  bit         m_full, m_pop, m_ovf;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mq.delete();
      evq.delete();
      check("reset_outputs",
            {m_valid, m_data, fifo_level, busy, err_frame, err_parity, err_tag, err_overflow}, 0);
    end else begin
      ev_kind = -1;
      ev_code = 2'b00;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev_kind = evq[0].kind;
        ev_code = evq[0].code;
        void'(evq.pop_front());
      end
      m_full   = (mq.size() == DEPTH);
      m_pop    = (mq.size() != 0) && m_ready;
      m_ovf    = (ev_kind == K_PUSH) && m_full && !m_pop;
      exp_head = (mq.size() != 0) ? mq[0] : 2'b00;
      check($sformatf("model@%0d", cyc),
            {m_valid, m_data, fifo_level, err_frame, err_parity, err_tag, err_overflow},
            {mq.size() != 0, exp_head, 3'(mq.size()), ev_kind == K_FRAME,
             ev_kind == K_PAR, ev_kind == K_TAG, m_ovf});
      if (m_pop) void'(mq.pop_front());
      if (ev_kind == K_PUSH && !m_ovf) mq.push_back(ev_code);
    end
  end

  // Event counters used by the literal checks.
  logic [1:0] got[$];
  int n_frame = 0, n_par = 0, n_tag = 0, n_ovf = 0;
  int pops_p = 0, n_perr_p = 0, n_other_p = 0;
  logic [1:0] last_p = 2'b00;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (err_frame)    n_frame++;
      if (err_parity)   n_par++;
      if (err_tag)      n_tag++;
      if (err_overflow) n_ovf++;
      if (m_valid_p && m_ready_p) begin pops_p++; last_p = m_data_p; end
      if (err_parity_p) n_perr_p++;
      if (err_frame_p || err_tag_p || err_overflow_p) n_other_p++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setline(input bit to_par, input logic v);
    if (to_par) rx_p = v;
    else        rx = v;
  endtask

  // One character: start, 8 data bits LSB first, optional parity, stop.
  task automatic send(input logic [7:0] data, input int par_mode, input bit par_flip,
                      input bit stop_bit, input bit to_par);
    int   k;
    logic x;
    ev_t  e;
    @(posedge clk);
    #1;
    k = cyc;
    if (!to_par) begin
      e.cyc  = k + LAT + ((par_mode != 0) ? 16 : 0);
      e.code = data[3:2];
      if (!stop_bit)                      e.kind = K_FRAME;
      else if (par_mode != 0 && par_flip) e.kind = K_PAR;
      else if (data[1:0] != 2'b01)        e.kind = K_TAG;
      else                                e.kind = K_PUSH;
      evq.push_back(e);
    end
    setline(to_par, 1'b0);
    step(16);
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      setline(to_par, data[i]);
      x = x ^ data[i];
      step(16);
    end
    if (par_mode != 0) begin
      setline(to_par, x ^ (par_mode == 2) ^ par_flip);
      step(16);
    end
    setline(to_par, stop_bit);
    step(16);
  endtask

  int   base;
  logic saw_busy;

  initial begin
    step(3);
    check("reset_state", {m_valid, m_data, fifo_level, busy, err_frame, err_parity,
                          err_tag, err_overflow}, 0);
    rst_n = 1'b1;
    step(20);

    // Four good codes, consumer always ready.
    send(8'h01, 0, 0, 1, 0);
    send(8'h05, 0, 0, 1, 0);
    send(8'h09, 0, 0, 1, 0);
    send(8'h0D, 0, 0, 1, 0);
    step(4);
    check("codes_count", got.size(), 4);
    check("code0", got[0], 2'b00);
    check("code1", got[1], 2'b01);
    check("code2", got[2], 2'b10);
    check("code3", got[3], 2'b11);
    check("no_errs", n_frame + n_par + n_tag + n_ovf, 0);

    // Tag mismatch.
    send(8'h02, 0, 0, 1, 0);
    step(4);
    check("tag_pulse", n_tag, 1);
    check("tag_no_push", got.size(), 4);
    check("tag_level", fifo_level, 0);

    // Parity instance: wrong parity bit, then correct.
    send(8'h05, 1, 1, 1, 1);
    step(4);
    check("par_pulse", n_perr_p, 1);
    check("par_no_push", pops_p, 0);
    send(8'h05, 1, 0, 1, 1);
    step(4);
    check("par_push", pops_p, 1);
    check("par_code", last_p, 2'b01);
    check("par_one_err", n_perr_p + n_other_p, 1);

    // Framing error followed by a held break.
    send(8'h0D, 0, 0, 0, 0);
    step(40);
    check("break_busy", busy, 1);
    rx = 1'b1;
    step(16);
    check("release_idle", busy, 0);
    send(8'h0D, 0, 0, 1, 0);
    step(4);
    check("frame_pulse", n_frame, 1);
    check("after_break_code", got[got.size()-1], 2'b11);

    // Frame error outranks tag error.
    send(8'h02, 0, 0, 0, 0);
    step(20);
    rx = 1'b1;
    step(16);
    check("prio_frame", n_frame, 2);
    check("prio_no_tag", n_tag, 1);

    // Fill to DEPTH, overflow on the fifth, then drain.
    m_ready = 1'b0;
    send(8'h01, 0, 0, 1, 0);
    send(8'h05, 0, 0, 1, 0);
    send(8'h09, 0, 0, 1, 0);
    send(8'h0D, 0, 0, 1, 0);
    send(8'h01, 0, 0, 1, 0);
    step(4);
    check("full_level", fifo_level, 4);
    check("ovf_pulse", n_ovf, 1);
    base = got.size();
    m_ready = 1'b1;
    step(6);
    check("drain_count", got.size() - base, 4);
    check("drain0", got[base], 2'b00);
    check("drain1", got[base+1], 2'b01);
    check("drain2", got[base+2], 2'b10);
    check("drain3", got[base+3], 2'b11);
    check("drain_level", fifo_level, 0);

    // Short glitch is rejected by the start-bit check.
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    check("glitch_busy", busy, 1);
    step(16);
    check("glitch_idle", busy, 0);
    check("glitch_no_err", n_frame + n_par + n_tag, 3);

    // Reset in the middle of a character with an entry already queued.
    m_ready = 1'b0;
    send(8'h01, 0, 0, 1, 0);
    step(2);
    check("pre_reset_level", fifo_level, 1);
    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(16);
    rx = 1'b0;
    step(8);
    rst_n = 1'b0;
    #1;
    check("rst_async", {m_valid, m_data, fifo_level, busy}, 0);
    step(3);
    rst_n = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      saw_busy = saw_busy | busy;
    end
    check("low_after_reset", saw_busy, 0);
    rx = 1'b1;
    m_ready = 1'b1;
    step(16);
    base = got.size();
    send(8'h09, 0, 0, 1, 0);
    step(4);
    check("post_reset_count", got.size() - base, 1);
    check("post_reset_code", got[got.size()-1], 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    failures++;
    $display("FAIL timeout actual=%0d required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Parametrised successor to the fixed 8N1 receive-and-decode path in fpga_top. It oversamples a UART line and supports configurable data bits and parity. Each received character is checked against a tag field, and a CODE_W-bit command code is extracted. Accepted codes are queued in a first-word-fall-through (FWFT) FIFO with a valid/ready output, and framing, parity, tag and overflow errors are each reported as a one-cycle pulse.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVS, 16, oversampling factor; must be at least 8 and even.
- DATA_BITS, 8, data bits per character; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- TAG_W, 2, width of the tag field in the data LSBs.
- TAG, 2'b01, tag value a character must carry to be accepted.
- CODE_W, 2, width of the code field, taken at data[TAG_W +: CODE_W]. TAG_W+CODE_W must not exceed DATA_BITS.
- DEPTH, 4, FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx  in  1  serial line, asynchronous to clk, idles high.
- m_data  out  CODE_W  FIFO head code.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head this cycle.
- fifo_level  out  $clog2(DEPTH)+1  number of entries held.
- busy  out  1  a frame is in progress (any state except IDLE).
- err_frame  out  1  one-cycle pulse: stop bit sampled low.
- err_parity  out  1  one-cycle pulse: parity mismatch.
- err_tag  out  1  one-cycle pulse: tag field did not match TAG.
- err_overflow  out  1  one-cycle pulse: good code dropped because the FIFO was full.

Behaviour:
- Reset values: m_valid=0, m_data=0, fifo_level=0, busy=0, all err_* = 0. FIFO pointers cleared, FSM returns to IDLE, divider and sample counter cleared.
- Reset mid-frame discards the partial character.
- After reset is released, the FSM must see rx_s=1 before it may detect a start bit.
- rx passes through a 2-flop synchroniser; rx_s is the synchronised line and all sampling uses it.
- Oversample tick = one clk pulse every DIV = round(CLK_FREQ/(BAUD*OVS)) clocks. DIV is computed at elaboration; DIV=1 means a tick every clock.
- Sample value = majority of rx_s at ticks OVS/2-1, OVS/2 and OVS/2+1 within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: a falling edge of rx_s moves to START and restarts the tick phase.
- START: a sample of 1 is a glitch; return to IDLE with no error and no pulse. A sample of 0 moves to DATA.
- DATA: shift DATA_BITS samples, LSB first. Then go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: sample the parity bit and compare with the XOR of the data bits (odd mode inverts the expected value).
- STOP: sample=1 ends the character and returns to IDLE at the bit midpoint (half a stop bit of resynchronisation margin). Sample=0 pulses err_frame and moves to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 so a break cannot retrigger; then go to IDLE.
- Error priority per character: frame > parity > tag. Exactly one err_* pulses for a bad character, and the character is not pushed.
- err_tag pulses when data[TAG_W-1:0]≠TAG and there is no frame or parity error.
- Push: a good character pushes data[TAG_W +: CODE_W] one clock after the stop-bit decision.
- Full FIFO:
  - Push while full with no pop in the same cycle: the code is dropped, err_overflow pulses, and the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted, and fifo_level is unchanged.
- Pop when m_valid & m_ready. A pop while empty is ignored.
- FWFT: m_data is valid whenever m_valid=1. The first push is visible on m_valid the following cycle.
- Latency: m_valid rises 2 clocks + (OVS/2+1)·DIV after the stop-bit midpoint window opens, and that latency must be fixed per build.
- Pointers wrap modulo DEPTH. fifo_level counts 0..DEPTH.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - rx_state_e FSM enum.
  - calc_div(clk, baud, ovs) constant function.
- Sub-module sync_fifo, holding the FIFO: parameters WIDTH and DEPTH, signals push/pop/full/empty/level.
- The FSM and sampler stay in uart_cmd_rx.

Test Plan:
Bench build: CLK_FREQ=1_600_000, BAUD=100_000, OVS=16 (DIV=1, 16 clocks per bit), TAG=2'b01; other parameters at default unless stated.
- Send 8N1 0x01, 0x05, 0x09, 0x0D with m_ready=1 -> m_data 00, 01, 10, 11 in order; each m_valid pulses 1 cycle; no err_*.
- Send 0x02 -> err_tag pulse; no m_valid; fifo_level stays 0.
- PARITY=1, send 0x05 with parity bit 1 (correct is 0) -> err_parity; no push. Resend with parity 0 -> m_data=01.
- Send 0x0D with stop bit low, hold rx low 40 clocks, release high 16 clocks, then send 0x0D -> one err_frame; busy high until release; then m_data=11.
- m_ready=0, send 0x01, 0x05, 0x09, 0x0D, 0x01 -> fifo_level=4, err_overflow on the 5th. Then m_ready=1 drains 00, 01, 10, 11 and level reaches 0.
- Glitch: rx low for 4 clocks -> no error, busy back to 0 within one bit. Assert rst_n low mid-DATA of 0x09 -> all outputs reset at once. After release, idle 16 clocks, send 0x09 -> m_data=10.
